// File: rtl/phy_pkg.sv
// Shared definitions for the two-lane PHY link (phy_tx and phy_rx).
package phy_pkg;

  localparam int          SYM_W              = 8;
  localparam logic [7:0]  COM_SYMBOL         = 8'hBC;
  localparam int          SYNC_COUNT_DEFAULT = 4;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } phy_state_t;

endpackage

// File: rtl/phy_tx_lane.sv
// One transmit lane: byte select, MSB-first shift register and registered serial bit.
module phy_tx_lane
  import phy_pkg::*;
(
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             load,
  input  logic [SYM_W-1:0] data_in,
  input  logic             valid_in,
  input  logic             force_com,
  output logic             data_out
);

  logic [SYM_W-1:0] shift_q;
  logic [SYM_W-1:0] sel_byte;

  // NOTE: give every always_comb output a default first, otherwise a missed branch infers a latch.
  // An X/Z valid makes the condition unknown, which falls through to COM.
  always_comb begin
    sel_byte = COM_SYMBOL;
    if (valid_in && !force_com) sel_byte = data_in;
  end

  // The MSB goes out on the load edge itself, so the line never idles between symbols.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      shift_q  <= '0;
      data_out <= 1'b0;
    end else if (load) begin
      shift_q  <= sel_byte;
      data_out <= sel_byte[SYM_W-1];
    end else begin
      shift_q  <= shift_q << 1;
      data_out <= shift_q[SYM_W-2];
    end
  end

endmodule

// File: rtl/phy_tx.sv
// Two-lane PHY transmitter: shared bit counter, training FSM and two serializing lanes.
module phy_tx
  import phy_pkg::*;
#(
  parameter int SYNC_COUNT = SYNC_COUNT_DEFAULT
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic [SYM_W-1:0] data_in_0,
  input  logic             valid_in_0,
  input  logic [SYM_W-1:0] data_in_1,
  input  logic             valid_in_1,
  output logic             ready_out,
  output logic             active_out,
  output logic             data_out0,
  output logic             data_out1
);

  phy_state_t state;
  logic [2:0] bit_cnt;
  logic [3:0] sync_cnt;
  logic       load;
  logic       force_com;

  assign load      = (bit_cnt == 3'd7);
  assign force_com = (state == SYNC);
  assign ready_out = (state == ACTIVE) && load;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state      <= SYNC;
      bit_cnt    <= 3'd7;
      sync_cnt   <= 4'd0;
      active_out <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (load && state == SYNC) begin
        sync_cnt <= sync_cnt + 4'd1;
        if (sync_cnt == 4'(SYNC_COUNT - 1)) begin
          state      <= ACTIVE;
          active_out <= 1'b1;
        end
      end
    end
  end

  phy_tx_lane u_lane0 (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .load      (load),
    .data_in   (data_in_0),
    .valid_in  (valid_in_0),
    .force_com (force_com),
    .data_out  (data_out0)
  );

  phy_tx_lane u_lane1 (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .load      (load),
    .data_in   (data_in_1),
    .valid_in  (valid_in_1),
    .force_com (force_com),
    .data_out  (data_out1)
  );

endmodule

// File: tb/tb_phy_tx.sv
// Scoreboard bench for phy_tx: stimulus queues expected symbols, a deserializing monitor checks them.
module tb_phy_tx;

  logic       clk_8f;
  logic       reset;
  logic [7:0] data_in_0, data_in_1;
  logic       valid_in_0, valid_in_1;
  logic       ready_out, active_out, data_out0, data_out1;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         mon_en = 1'b0;
  int         bit_idx = 0;
  logic [7:0] sh0, sh1;

  phy_tx dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .data_in_0  (data_in_0),
    .valid_in_0 (valid_in_0),
    .data_in_1  (data_in_1),
    .valid_in_1 (valid_in_1),
    .ready_out  (ready_out),
    .active_out (active_out),
    .data_out0  (data_out0),
    .data_out1  (data_out1)
  );

  initial clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge; symbols start on the first edge after release.
  always @(negedge clk_8f) begin
    if (!mon_en) begin
      bit_idx = 0;
    end else begin
      sh0 = {sh0[6:0], data_out0};
      sh1 = {sh1[6:0], data_out1};
      bit_idx++;
      if (bit_idx == 8) begin
        bit_idx = 0;
        if (q0.size() == 0 || q1.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_underflow: got symbol %h/%h required none queued", sh0, sh1);
        end else begin
          check("lane0_sym", sh0, q0.pop_front());
          check("lane1_sym", sh1, q1.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    reset  = 1'b0;
    mon_en = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check("rst_out0",   data_out0,  1'b0);
    check("rst_out1",   data_out1,  1'b0);
    check("rst_active", active_out, 1'b0);
    check("rst_ready",  ready_out,  1'b0);
    repeat (2) @(negedge clk_8f);
    reset = 1'b1;
    #1 mon_en = 1'b1;
  endtask

  // Drives one symbol slot from the cycle before its load edge through the next slot's entry.
  task automatic slot(input bit exp_rdy, input bit exp_act,
                      input logic v0, input logic [7:0] d0, input logic [7:0] e0,
                      input logic v1, input logic [7:0] d1, input logic [7:0] e1,
                      input bit glitch);
    valid_in_0 = v0; data_in_0 = d0;
    valid_in_1 = v1; data_in_1 = d1;
    q0.push_back(e0);
    q1.push_back(e1);
    check("ready_at_load", ready_out, exp_rdy);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_8f);
      if (c == 0) begin
        check("active_after_load", active_out, exp_act);
        valid_in_0 = 1'b0; data_in_0 = 8'hxx;
        valid_in_1 = 1'b0; data_in_1 = 8'hxx;
      end
      if (glitch && c == 2) begin valid_in_0 = 1'b1; data_in_0 = 8'h12; end
      if (glitch && c == 5) begin valid_in_0 = 1'b0; data_in_0 = 8'h00; end
      if (c < 7) check("ready_mid", ready_out, 1'b0);
    end
  endtask

  task automatic training();
    for (int i = 0; i < 4; i++)
      slot(1'b0, (i == 3), 1'b1, 8'h55, 8'hBC, 1'b1, 8'hAA, 8'hBC, 1'b0);
  endtask

  logic [7:0] r0, r1;

  initial begin
    reset = 1'b0;
    valid_in_0 = 1'b0; valid_in_1 = 1'b0;
    data_in_0 = 8'h00; data_in_1 = 8'h00;
    @(negedge clk_8f);
    do_reset();

    // Training ignores inputs, then idle COMs with valids low.
    training();
    for (int i = 0; i < 4; i++)
      slot(1'b1, 1'b1, 1'b0, 8'h00, 8'hBC, 1'b0, 8'h00, 8'hBC, 1'b0);

    slot(1'b1, 1'b1, 1'b1, 8'hA5, 8'hA5, 1'b1, 8'h3C, 8'h3C, 1'b0);
    slot(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'h99, 8'hBC, 1'b0);
    slot(1'b1, 1'b1, 1'b0, 8'h00, 8'hBC, 1'b0, 8'h00, 8'hBC, 1'b1);
    slot(1'b1, 1'b1, 1'b1, 8'hBC, 8'hBC, 1'bx, 8'h77, 8'hBC, 1'b0);
    slot(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h01, 8'h01, 1'b0);

    // Reset in the middle of a data symbol: partial symbol dropped, training repeats.
    valid_in_0 = 1'b1; data_in_0 = 8'h5A;
    valid_in_1 = 1'b1; data_in_1 = 8'hC3;
    repeat (4) @(negedge clk_8f);
    #2;
    do_reset();
    training();

    for (int i = 0; i < 16; i++) begin
      r0 = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      slot(1'b1, 1'b1, 1'b1, r0, r0, 1'b1, r1, r1, 1'b0);
    end

    #1;
    check("sb_drained0", 8'(q0.size()), 8'd0);
    check("sb_drained1", 8'(q1.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/phy_tx.md
Name: phy_tx

Overview:
Transmit side of the two-lane PHY link; it pairs with the phy_rx deserializer.
- Accepts one byte per lane per symbol period and serializes it MSB-first onto data_out0/data_out1, one bit per clk_8f cycle.
- After reset it emits a training burst of COM symbols (0xBC) on both lanes so the receiver can lock. It then sends data, or COM as idle filler whenever a lane has no valid byte.

Parameters:
WIDTH, 8, symbol width in bits (fixed at 8; bit counter is 3 bits).
COM_SYMBOL, 8'hBC, sync/idle symbol, sent MSB-first as 1,0,1,1,1,1,0,0.
SYNC_COUNT, 4, number of COM symbols per lane sent after reset before data is accepted (range 1..15).

Ports:
clk_8f  input  1  bit clock; all logic on its rising edge
reset  input  1  asynchronous, active-low reset
data_in_0  input  8  lane-0 parallel byte
valid_in_0  input  1  lane-0 byte valid
data_in_1  input  8  lane-1 parallel byte
valid_in_1  input  1  lane-1 byte valid
ready_out  output  1  high during the cycle in which inputs are sampled at the next edge
active_out  output  1  high once training has completed
data_out0  output  1  lane-0 serial bit (registered)
data_out1  output  1  lane-1 serial bit (registered)

Behaviour:
- Reset (reset==0, asynchronous): data_out0=0, data_out1=0, active_out=0, bit_cnt=7, sync_cnt=0, state=SYNC, both shift registers cleared.
- ready_out is combinational: ready_out = (state==ACTIVE) && (bit_cnt==7). It is therefore 0 during reset.
- bit_cnt increments mod 8 on every edge. An edge at which bit_cnt==7 is a load edge.
- Load edge, per lane: the selected byte B goes into the shift register and data_out <= B[7] on that same edge. The following 7 edges drive B[6]..B[0]. The LSB is driven at load edge +7, and the next load edge follows immediately, so there are no gap bits.
- FSM SYNC:
  - On every load edge, B = COM_SYMBOL on both lanes; inputs are ignored and sync_cnt increments.
  - On the load edge where sync_cnt==SYNC_COUNT-1, state moves to ACTIVE and active_out <= 1.
- FSM ACTIVE: on every load edge, per lane independently, B = valid_in_x ? data_in_x : COM_SYMBOL.
- FSM ACTIVE is terminal. It is left only by reset.
- Timing from reset release, numbering edges from 1:
  - COM#1..#4 are loaded at edges 1, 9, 17 and 25.
  - active_out rises after edge 25.
  - ready_out is high between edges 32 and 33.
  - The first user byte is sampled at edge 33, and its MSB appears on the line right after edge 33.
- Handshake: upstream must hold data/valid stable across the load edge (the one at which ready_out is high). Values on other cycles are don't-care. There is no backpressure, so the byte rate is fixed at 1 per 8 clk_8f per lane.
- Lanes are always symbol-aligned and share bit_cnt. A valid byte on one lane with an invalid byte on the other sends data and COM in the same slot.
- A valid byte equal to 0xBC is transmitted unchanged; the receiver will treat it as COM. This is a documented protocol limitation, and the block does no escaping.
- Reset mid-symbol: the partial symbol is dropped and outputs go to 0 immediately. After release the full SYNC_COUNT training burst repeats.
- valid_in_x sampled as X/Z: treated as 0, so COM is sent.

Decomposition:
- Shared package phy_pkg holds:
  - COM_SYMBOL = 8'hBC
  - SYNC_COUNT default
  - symbol width constant
  - FSM state encoding (SYNC=1'b0, ACTIVE=1'b1)
  phy_rx uses the same package.
- Sub-module phy_tx_lane is instantiated twice.
  - It contains the 8-bit shift register, the data/COM select mux and the registered serial output.
  - Inputs: load strobe, byte, valid, force_com.
- phy_tx top owns bit_cnt, sync_cnt, the FSM, ready_out and active_out.

Test Plan:
- Reset, then release with valids low for 64 cycles -> both lanes emit 8 consecutive COMs (bit pattern 10111100 repeated); active_out rises after edge 25; ready_out pulses every 8 cycles from edge 32.
- After training, drive lane0=0xA5 valid and lane1=0x3C valid at the ready_out edge -> data_out0 shows 1,0,1,0,0,1,0,1 and data_out1 shows 0,0,1,1,1,1,0,0 on edges 33..40; phy_rx loopback reports data_out_0=0xA5 and data_out_1=0x3C with their valids.
- Drive lane0 valid 0xFF with lane1 valid=0 -> lane0 sends 11111111, lane1 sends COM; the receiver's valid_out_1 stays low.
- Assert valid_in_0 with data 0x12 on a cycle where ready_out==0, then deassert before the load edge -> byte not sent; COM is transmitted.
- Assert reset low at bit 3 of a data symbol -> outputs go to 0 immediately; after release, 4 fresh COMs precede any data and ready_out first rises after edge 32 again.
- Back-to-back stream of 16 random bytes per lane -> loopback through phy_rx gives identical byte sequences; no idle bits between symbols (checked with a scoreboard).
